memory_stage: RTL

Y86-64 SEQ memory stage, directly upstream of write-back. Takes the decoded and executed instruction (icode, valE, valA, valP, stat) and performs the single data-memory access it needs over a req/ack memory port. Hands valM, final stat and passthrough fields to write-back over a valid/ready handshake. Status becomes sticky once it leaves AOK.

---
 rtl/y86_pkg.sv | 32 +++
 rtl/mem_access_decode.sv | 40 ++++
 rtl/memory_stage.sv | 127 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes and memory-stage state encoding.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REQ    = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  // 65-bit sum so that addr+8 wrapping past 2^64 is treated as out of range.
  function automatic logic addr_in_range(input logic [63:0] addr, input logic [64:0] limit);
    return ({1'b0, addr} + 65'd8) <= limit;
  endfunction

endpackage

// File: rtl/mem_access_decode.sv
// Combinational map from a decoded instruction to its single data-memory access.
module mem_access_decode
  import y86_pkg::*;
(
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  output logic        access,
  output logic        we,
  output logic [63:0] addr,
  output logic [63:0] wdata
);

  always_comb begin
    access = 1'b0;
    we     = 1'b0;
    addr   = valE;
    wdata  = valA;
    case (icode)
      IRMMOVQ, IPUSHQ: begin
        access = 1'b1;
        we     = 1'b1;
      end
      IMRMOVQ: access = 1'b1;
      ICALL: begin
        access = 1'b1;
        we     = 1'b1;
        wdata  = valP;
      end
      // ret and popq read from the old stack pointer.
      IRET, IPOPQ: begin
        access = 1'b1;
        addr   = valA;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// Y86-64 SEQ memory stage: one req/ack data access per instruction, valid/ready to write-back.
// Optional MEM_TIMEOUT_EN aborts a request that waits TIMEOUT_CYCLES without mem_ack.
module memory_stage
  import y86_pkg::*;
#(
  parameter longint unsigned MEM_BYTES      = 8192,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  icode,
  input  logic [63:0] valE,
  input  logic [63:0] valA,
  input  logic [63:0] valP,
  input  logic [2:0]  stat_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  icode_out,
  output logic [63:0] valE_out,
  output logic [63:0] valM,
  output logic [2:0]  stat_out
);

  logic [1:0]  state;
  logic        dec_access;
  logic        dec_we;
  logic [63:0] dec_addr;
  logic [63:0] dec_wdata;
  logic        in_rng;

  mem_access_decode u_decode (
    .icode  (icode),
    .valE   (valE),
    .valA   (valA),
    .valP   (valP),
    .access (dec_access),
    .we     (dec_we),
    .addr   (dec_addr),
    .wdata  (dec_wdata)
  );

  assign in_rng    = addr_in_range(dec_addr, 65'(MEM_BYTES));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == RESP);

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW =
      ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      icode_out <= '0;
      valE_out  <= '0;
      valM      <= '0;
      stat_out  <= SAOK;
`ifdef MEM_TIMEOUT_EN
      cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            icode_out <= icode;
            valE_out  <= valE;
            valM      <= '0;
            if (dec_access && (stat_in == SAOK) && in_rng) begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= dec_we;
              mem_addr  <= dec_addr;
              mem_wdata <= dec_wdata;
`ifdef MEM_TIMEOUT_EN
              cnt       <= '0;
`endif
            end else begin
              state <= RESP;
              if (stat_in != SAOK)  stat_out <= stat_in;
              else if (dec_access)  stat_out <= SADR;
              else                  stat_out <= SAOK;
            end
          end
        end
        REQ: begin
          if (mem_ack) begin
            state    <= RESP;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            valM     <= mem_we ? 64'd0 : mem_rdata;
            stat_out <= mem_err ? SADR : SAOK;
          end
`ifdef MEM_TIMEOUT_EN
          else if (cnt == CntW'(TIMEOUT_CYCLES - 1)) begin
            state    <= RESP;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            valM     <= '0;
            stat_out <= SADR;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          if (out_ready) state <= (stat_out == SAOK) ? IDLE : HALTED;
        end
        default: ;  // HALTED: only reset leaves
      endcase
    end
  end

endmodule
